trace_buffer: RTL

Parametrised instruction-trace capture unit for the RV32I core. It sits beside the datapath and samples each retired instruction's PC, instruction word, destination register and write-back data into a circular buffer. A PC-match or forced trigger freezes the buffer after a programmable number of post-trigger entries. The frozen trace is read back oldest-first through a single-cycle read port, replacing free-running `$monitor` dumps with a bounded, synthesizable record.

---
 rtl/trace_buffer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/trace_buffer.sv
// Instruction-trace capture unit: records retired instructions into a circular buffer,
// freezes a programmable number of entries after a PC-match or forced trigger, reads back oldest-first.
module trace_buffer #(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_arm,
  input  logic                       i_abort,
  input  logic                       i_force_trig,
  input  logic [XLEN-1:0]            i_trig_pc,
  input  logic                       i_valid,
  input  logic [XLEN-1:0]            i_pc,
  input  logic [31:0]                i_instr,
  input  logic [4:0]                 i_rd,
  input  logic                       i_reg_write,
  input  logic [XLEN-1:0]            i_wdata,
  input  logic                       i_rd_req,
  input  logic [$clog2(DEPTH)-1:0]   i_rd_idx,
  output logic                       o_rd_valid,
  output logic                       o_rd_err,
  output logic [XLEN-1:0]            o_rd_pc,
  output logic [31:0]                o_rd_instr,
  output logic [4:0]                 o_rd_rd,
  output logic                       o_rd_we,
  output logic [XLEN-1:0]            o_rd_wdata,
  output logic [1:0]                 o_state,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic [$clog2(DEPTH)-1:0]   o_trig_pos
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
  localparam logic [CW-1:0] POST_TRIG_C = CW'(POST_TRIG);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [4:0]      rd;
    logic            we;
    logic [XLEN-1:0] wdata;
  } entry_t;

  state_t          r_state;
  logic [AW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   r_post_cnt;
  logic [AW-1:0]   r_trig_slot;

  entry_t          r_mem [DEPTH];
  entry_t          r_rd_data;
  logic            r_rd_valid;
  logic            r_rd_err;

  entry_t          w_entry;
  logic            w_capture;
  logic            w_trig;
  logic [AW-1:0]   w_oldest;
  logic [AW-1:0]   w_rd_addr;
  logic            w_rd_err;
  logic            w_rd_ok;
  logic [CW-1:0]   w_post_next;

  assign w_entry = '{pc: i_pc, instr: i_instr, rd: i_rd, we: i_reg_write, wdata: i_wdata};

  // abort and arm both pre-empt the capture of the same cycle's entry
  assign w_capture = !reset && !i_abort && !i_arm && i_valid &&
                     (r_state == ST_ARMED || r_state == ST_POST);
  assign w_trig    = (r_state == ST_ARMED) && i_valid &&
                     ((i_pc == i_trig_pc) || i_force_trig);

  assign w_oldest    = (r_count == DEPTH_C) ? r_wr_ptr : '0;
  assign w_rd_addr   = w_oldest + i_rd_idx;
  assign w_rd_err    = (r_state != ST_DONE) || ({1'b0, i_rd_idx} >= r_count);
  assign w_post_next = r_post_cnt + CW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_post_cnt  <= '0;
      r_trig_slot <= '0;
    end else if (i_abort) begin
      r_state <= ST_IDLE;
    end else if (i_arm) begin
      r_state    <= ST_ARMED;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_post_cnt <= '0;
    end else begin
      if (w_capture) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        if (r_count != DEPTH_C) begin
          r_count <= r_count + CW'(1);
        end
      end
      case (r_state)
        ST_ARMED: begin
          if (w_trig) begin
            r_trig_slot <= r_wr_ptr;
            r_state     <= (POST_TRIG == 0) ? ST_DONE : ST_POST;
          end
        end
        ST_POST: begin
          if (i_valid) begin
            r_post_cnt <= w_post_next;
            if (w_post_next == POST_TRIG_C) begin
              r_state <= ST_DONE;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Storage has no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  always_ff @(posedge clk) begin
    r_rd_data <= r_mem[w_rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
    end else begin
      r_rd_valid <= i_rd_req;
      r_rd_err   <= i_rd_req && w_rd_err;
    end
  end

  // Data fields are forced to zero unless a good response is being presented
  assign w_rd_ok    = r_rd_valid && !r_rd_err;
  assign o_rd_valid = r_rd_valid;
  assign o_rd_err   = r_rd_err;
  assign o_rd_pc    = w_rd_ok ? r_rd_data.pc    : '0;
  assign o_rd_instr = w_rd_ok ? r_rd_data.instr : '0;
  assign o_rd_rd    = w_rd_ok ? r_rd_data.rd    : '0;
  assign o_rd_we    = w_rd_ok ? r_rd_data.we    : 1'b0;
  assign o_rd_wdata = w_rd_ok ? r_rd_data.wdata : '0;

  assign o_state    = r_state;
  assign o_count    = r_count;
  assign o_trig_pos = r_trig_slot - w_oldest;

endmodule
